bcd_adder_seq: RTL and testbench
================================

# bcd_adder_seq

Parametrised multi-digit BCD adder/subtractor that processes one decimal digit per clock, least significant digit first. It accepts two packed BCD operands through a valid/ready handshake and returns the packed BCD result with carry/borrow and an input-error flag. It is the sequential, N-digit successor to the single-digit combinational BCD adder. It sits between operand registers and a display or accumulator path.

## Interface
- DIGITS, default 4: number of BCD digits per operand; legal range 1 to 16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block idle and able to accept a request.
- a  input  4*DIGITS  operand A, packed BCD; digit 0 in bits [3:0].
- b  input  4*DIGITS  operand B, packed BCD.
- sub  input  1  0 selects A+B+cin; 1 selects A-B-cin.
- cin  input  1  carry-in in add mode; borrow-in in subtract mode.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- sum  output  4*DIGITS  packed BCD result.
- cout  output  1  carry-out in add mode; borrow-out in subtract mode.
- err  output  1  at least one operand digit was greater than 9.

## Operation
- FSM states and transitions:
  - IDLE -> RUN on in_valid && in_ready.
  - RUN -> DONE after the digit counter reaches DIGITS-1.
  - DONE -> IDLE on out_valid && out_ready.
- Output decode: in_ready = (state==IDLE); out_valid = (state==DONE).
- On accept, the block captures a, b, sub and cin. The digit counter is cleared. The internal carry c is initialised to cin in add mode and to ~cin in subtract mode.
- Input checking: err is computed at accept as the OR of (digit > 9) over all digits of a and b, and registered.
- Each RUN cycle handles digit i = counter:
  - bb = b_i in add mode; bb = 9 - b_i in subtract mode.
  - t = a_i + bb + c, a 5-bit value with range 0 to 19 for legal digits.
  - If t > 9: sum_i = t - 10 and c = 1. Otherwise: sum_i = t and c = 0.
  - sum_i is written into digit slot i of the result register.
- Final carry: in add mode, cout = final c. In subtract mode, cout = ~final c, so 1 means a borrow occurred.
- Subtract result with a borrow is the ten's complement: 10^DIGITS + A - B - cin.
- Error result: when err = 1, sum and cout are forced to 0 in DONE. Latency is unchanged.
- sum, cout and err are held stable throughout DONE regardless of the inputs.
- While the block is not in IDLE, in_valid and all operand inputs are ignored.

## Timing
- Reset: while rst_n is low, the FSM is forced to IDLE (asynchronous). Reset values:
  - sum = 0, cout = 0, err = 0, out_valid = 0.
  - in_ready = 1.
  - Digit counter = 0.
- Reset is valid at any point, including mid-RUN and in DONE. Any in-flight operation is discarded and no out_valid is produced for it.
- Latency: with the accept edge taken as edge 0, the block spends RUN on edges 1..DIGITS. out_valid is first high after edge DIGITS, i.e. DIGITS cycles after acceptance.
- Result handshake: out_valid stays high until an edge at which out_ready = 1. in_ready is high from the following cycle.
- Throughput: at most one operation per DIGITS+2 cycles (one IDLE accept cycle, DIGITS RUN cycles, at least one DONE cycle).
- No combinational path exists from in_valid to in_ready, or from out_ready to out_valid.
- DIGITS = 1 degenerates to one RUN cycle. With add mode and cin = 0, it reproduces the single-digit adder: sum = ones digit, cout = tens digit.

## Test plan
- DIGITS=4, add, cin=0: a=0x1234, b=0x5678 -> sum=0x6912, cout=0, err=0. out_valid rises exactly 4 cycles after the accept edge.
- DIGITS=4, add, cin=1: a=0x9999, b=0x0000 -> sum=0x0000, cout=1. Then a=0x0500, b=0x0499, cin=0 -> sum=0x0999, cout=0.
- DIGITS=4, subtract, cin=0:
  - a=0x0500, b=0x0123 -> sum=0x0377, cout=0.
  - a=0x0003, b=0x0005 -> sum=0x9998, cout=1.
  - a=b=0x4321 -> sum=0x0000, cout=0.
- Error input: a=0x12A4, b=0x0001 -> err=1, sum=0, cout=0, with latency still 4. The next legal operation returns err=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid, a and b -> sum, cout and err stay stable, in_ready=0, and no new accept occurs. Then raise out_ready -> in_ready=1 on the next cycle. A back-to-back second operation completes correctly.
- Reset: assert rst_n low during the 2nd RUN cycle -> outputs zero immediately and no stale out_valid appears. After release, 9+9 with DIGITS=1 -> sum=0x8, cout=1.

Source files
------------

// File: rtl/bcd_adder_seq.sv
// bcd_adder_seq
// Multi-digit BCD adder/subtractor that processes one decimal digit per clock,
// least significant digit first. Operands arrive through a valid/ready request
// handshake; the packed BCD result, carry/borrow and an input-error flag are
// returned through a valid/ready result handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand request
//   in_ready   block idle, request will be accepted
//   a, b       packed BCD operands, digit 0 in bits [3:0]
//   sub        0: a + b + cin, 1: a - b - cin
//   cin        carry-in (add) / borrow-in (subtract)
//   out_valid  result available
//   out_ready  consumer takes the result
//   sum        packed BCD result (ten's complement when a borrow occurred)
//   cout       carry-out (add) / borrow-out (subtract)
//   err        some operand digit was greater than 9; sum and cout read 0
module bcd_adder_seq #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                sub,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int CW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // Digit lookup tables are padded to a power of two so the counter can
    // index them at full width without an out-of-range slot.
    localparam int SLOTS = 1 << CW;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_reg, state_next;
    logic [4*DIGITS-1:0] a_reg, b_reg, res_reg;
    logic                sub_reg, c_reg, cout_reg, err_reg;
    logic [CW-1:0]       cnt_reg;

    logic [3:0]          a_dig [SLOTS];
    logic [3:0]          b_dig [SLOTS];
    logic [DIGITS-1:0]   bad_dig;

    logic [3:0]          a_i, b_i, bb, s_i;
    logic [4:0]          t;
    logic                carry, last_digit, accept;

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < DIGITS) begin : g_real
                assign a_dig[gi] = a_reg[4*gi +: 4];
                assign b_dig[gi] = b_reg[4*gi +: 4];
            end else begin : g_pad
                assign a_dig[gi] = 4'd0;
                assign b_dig[gi] = 4'd0;
            end
        end
        // Operand validity is judged on the live inputs at accept time.
        for (gi = 0; gi < DIGITS; gi++) begin : g_chk
            assign bad_dig[gi] = (a[4*gi +: 4] > 4'd9) || (b[4*gi +: 4] > 4'd9);
        end
    endgenerate

    // One decimal digit step. Subtraction uses the nine's complement of b with
    // the carry preloaded to ~cin, giving a - b - cin as a ten's complement sum.
    always_comb begin
        a_i   = a_dig[cnt_reg];
        b_i   = b_dig[cnt_reg];
        bb    = sub_reg ? (4'd9 - b_i) : b_i;
        t     = {1'b0, a_i} + {1'b0, bb} + {4'b0000, c_reg};
        carry = (t > 5'd9);
        s_i   = carry ? 4'(t - 5'd10) : t[3:0];
    end

    assign last_digit = (cnt_reg == CW'(DIGITS - 1));
    assign accept     = (state_reg == IDLE) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_digit) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            res_reg  <= '0;
            sub_reg  <= 1'b0;
            c_reg    <= 1'b0;
            cout_reg <= 1'b0;
            err_reg  <= 1'b0;
            cnt_reg  <= '0;
        end else if (accept) begin
            a_reg    <= a;
            b_reg    <= b;
            sub_reg  <= sub;
            c_reg    <= sub ? ~cin : cin;
            cnt_reg  <= '0;
            res_reg  <= '0;
            cout_reg <= 1'b0;
            err_reg  <= |bad_dig;
        end else if (state_reg == RUN) begin
            res_reg[4*cnt_reg +: 4] <= s_i;
            c_reg                   <= carry;
            if (last_digit) begin
                // A missing final carry in subtract mode means a borrow.
                cout_reg <= sub_reg ? ~carry : carry;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Bad operands report a zero result while keeping the normal latency.
    assign sum  = err_reg ? '0 : res_reg;
    assign cout = cout_reg & ~err_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_bcd_adder_seq.sv
module tb_bcd_adder_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv4 = 1'b0, iv1 = 1'b0;
    logic        rdy4, rdy1, ov4, ov1;
    logic [15:0] a_in = '0, b_in = '0;
    logic        sub_in = 1'b0, cin_in = 1'b0, out_ready = 1'b0;
    logic [15:0] sum4;
    logic [3:0]  sum1;
    logic        cout4, cout1, err4, err1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_adder_seq #(.DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(rdy4),
        .a(a_in), .b(b_in), .sub(sub_in), .cin(cin_in),
        .out_valid(ov4), .out_ready(out_ready),
        .sum(sum4), .cout(cout4), .err(err4)
    );

    bcd_adder_seq #(.DIGITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1),
        .a(a_in[3:0]), .b(b_in[3:0]), .sub(sub_in), .cin(cin_in),
        .out_valid(ov1), .out_ready(out_ready),
        .sum(sum1), .cout(cout1), .err(err1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal value arithmetic on the whole operands.
    function automatic void ref_model(input int nd, input logic [15:0] x, input logic [15:0] y,
                                      input logic s, input logic ci,
                                      output logic [15:0] r, output logic co, output logic e);
        longint va = 0, vb = 0, m = 1, res;
        e = 1'b0;
        for (int i = 0; i < nd; i++) begin
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) e = 1'b1;
            va += longint'(x[4*i +: 4]) * m;
            vb += longint'(y[4*i +: 4]) * m;
            m  *= 10;
        end
        if (!s) begin
            res = va + vb + longint'(ci);
            co  = (res >= m);
            res = res % m;
        end else begin
            res = va - vb - longint'(ci);
            co  = (res < 0);
            if (res < 0) res += m;
        end
        r = '0;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(res % 10);
            res = res / 10;
        end
        if (e) begin
            r  = '0;
            co = 1'b0;
        end
    endfunction

    function automatic logic [15:0] rand_bcd(input int nd, input bit allow_bad);
        logic [15:0] v = '0;
        for (int i = 0; i < nd; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && $urandom_range(0, 7) == 0)
            v[4*$urandom_range(0, nd-1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    task automatic run_op(input bit one, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic ts, input logic tc, input bit release_now, input string tag);
        int          nd = one ? 1 : 4;
        int          cyc;
        logic [15:0] xa, xb, es, gs;
        logic        ec, ee, gc, ge;
        xa = one ? {12'h000, ta[3:0]} : ta;
        xb = one ? {12'h000, tb_v[3:0]} : tb_v;
        ref_model(nd, xa, xb, ts, tc, es, ec, ee);
        cyc = 0;
        while (!(one ? rdy1 : rdy4) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "/in_ready"}, one ? rdy1 : rdy4, 1);
        a_in = xa; b_in = xb; sub_in = ts; cin_in = tc;
        if (one) iv1 = 1'b1; else iv4 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0; iv4 = 1'b0;
        cyc = 0;
        while (!(one ? ov1 : ov4) && cyc < 3*nd + 10) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "/latency"}, cyc, nd);
        gs = one ? {12'h000, sum1} : sum4;
        gc = one ? cout1 : cout4;
        ge = one ? err1 : err4;
        check_eq({tag, "/sum"}, gs, es);
        check_eq({tag, "/cout"}, gc, ec);
        check_eq({tag, "/err"}, ge, ee);
        $display("op %s d=%0d a=%h b=%h sub=%0d cin=%0d -> sum=%h cout=%0d err=%0d (exp %h %0d %0d) lat=%0d",
                 tag, nd, xa, xb, ts, tc, gs, gc, ge, es, ec, ee, cyc);
        if (release_now) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check_eq({tag, "/ready_after"}, one ? rdy1 : rdy4, 1);
            check_eq({tag, "/ov_after"}, one ? ov1 : ov4, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hs;
        logic        hc, he;
        int          stale;

        @(negedge clk);
        @(negedge clk);
        check_eq("rst/in_ready", rdy4, 1);
        check_eq("rst/out_valid", ov4, 0);
        check_eq("rst/sum", sum4, 0);
        check_eq("rst/cout", cout4, 0);
        check_eq("rst/err", err4, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 16'h1234, 16'h5678, 0, 0, 1, "add_basic");
        run_op(0, 16'h9999, 16'h0000, 0, 1, 1, "add_cin_wrap");
        run_op(0, 16'h0500, 16'h0499, 0, 0, 1, "add_0999");
        run_op(0, 16'h0500, 16'h0123, 1, 0, 1, "sub_pos");
        run_op(0, 16'h0003, 16'h0005, 1, 0, 1, "sub_borrow");
        run_op(0, 16'h4321, 16'h4321, 1, 0, 1, "sub_zero");
        run_op(0, 16'h12A4, 16'h0001, 0, 0, 1, "err_digit");
        run_op(0, 16'h0001, 16'h0002, 0, 0, 1, "after_err");

        // Backpressure: result held while the request side is toggled.
        run_op(0, 16'h2718, 16'h3141, 0, 1, 0, "bp");
        ref_model(4, 16'h2718, 16'h3141, 0, 1, hs, hc, he);
        for (int k = 0; k < 3; k++) begin
            iv4 = ~iv4;
            a_in = 16'($urandom); b_in = 16'($urandom); sub_in = ~sub_in;
            @(negedge clk);
            check_eq("bp/sum", sum4, hs);
            check_eq("bp/cout", cout4, hc);
            check_eq("bp/err", err4, he);
            check_eq("bp/in_ready", rdy4, 0);
            check_eq("bp/out_valid", ov4, 1);
        end
        iv4 = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("bp/ready_next", rdy4, 1);
        check_eq("bp/ov_next", ov4, 0);
        run_op(0, 16'h8765, 16'h0235, 1, 1, 1, "bp_next");

        for (int n = 0; n < 30; n++)
            run_op(0, rand_bcd(4, 1), rand_bcd(4, 1), 1'($urandom), 1'($urandom), 1, "rnd4");
        for (int n = 0; n < 10; n++)
            run_op(1, rand_bcd(1, 1), rand_bcd(1, 1), 1'($urandom), 1'($urandom), 1, "rnd1");

        // Reset in the middle of an operation.
        a_in = 16'h5555; b_in = 16'h4444; sub_in = 1'b0; cin_in = 1'b0;
        iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst/out_valid", ov4, 0);
        check_eq("mid_rst/in_ready", rdy4, 1);
        check_eq("mid_rst/sum", sum4, 0);
        check_eq("mid_rst/cout", cout4, 0);
        check_eq("mid_rst/err", err4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ov4) stale++;
        end
        check_eq("mid_rst/stale_ov", stale, 0);
        run_op(1, 16'h0009, 16'h0009, 0, 0, 1, "d1_9p9");
        check_eq("d1_9p9/sum_direct", sum1, 4'h8);
        check_eq("d1_9p9/cout_direct", cout1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
